bfly11_stage: RTL and testbench



---
 rtl/fft_pkg.sv | 6 +
 rtl/counter.sv | 27 ++
 rtl/bfly11_stage.sv | 91 +++++++++
 tb/tb_bfly11_stage.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants for the FFT butterfly stages: lane geometry and default sample width.
package fft_pkg;
    localparam int LANES      = 16;
    localparam int HALF_LANES = 8;
    localparam int DEF_WIDTH  = 12;
endpackage

// File: rtl/counter.sv
// Enabled modulo counter: advances on en and wraps from COUNT_MAX_VAL-1 to 0.
module counter #(
    parameter int COUNT_MAX_VAL = 4,
    parameter int CW            = 4
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    output logic [CW-1:0] count
);

    // count register with synchronous active-low clear and wrap at the frame length
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count <= {CW{1'b0}};
        end else if (en) begin
            if (count == CW'(COUNT_MAX_VAL - 1)) begin
                count <= {CW{1'b0}};
            end else begin
                count <= count + CW'(1);
            end
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/bfly11_stage.sv
// Stage-11 radix-2 butterfly over 16 complex lanes with one-cycle registered latency
// and a per-frame beat index travelling alongside the data.
module bfly11_stage
    import fft_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CLK_CNT = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    twd10_valid,
    input  logic signed [WIDTH-1:0] twd_10_sum_re   [0:15],
    input  logic signed [WIDTH-1:0] twd_10_sum_im   [0:15],
    input  logic signed [WIDTH-1:0] twd_10_diff_re  [0:15],
    input  logic signed [WIDTH-1:0] twd_10_diff_im  [0:15],
    output logic signed [WIDTH:0]   o_11bfly_sum_re [0:15],
    output logic signed [WIDTH:0]   o_11bfly_sum_im [0:15],
    output logic signed [WIDTH:0]   o_11bfly_diff_re[0:15],
    output logic signed [WIDTH:0]   o_11bfly_diff_im[0:15],
    output logic                    twd11_valid,
    output logic [3:0]              o_beat_idx,
    output logic                    o_frame_last
);

    localparam int OW = WIDTH + 1;

    logic signed [OW-1:0] add_re_s [0:LANES-1];
    logic signed [OW-1:0] add_im_s [0:LANES-1];
    logic signed [OW-1:0] sub_re_s [0:LANES-1];
    logic signed [OW-1:0] sub_im_s [0:LANES-1];
    logic [3:0]           beat_cnt_s;

    // One guard bit is enough for a single add/sub, so nothing can overflow.
    function automatic logic signed [OW-1:0] sext(input logic signed [WIDTH-1:0] x);
        return {x[WIDTH-1], x};
    endfunction

    genvar j;
    generate
        for (j = 0; j < HALF_LANES; j++) begin : g_bfly
            assign add_re_s[j] = sext(twd_10_sum_re[j]) + sext(twd_10_sum_re[j+HALF_LANES]);
            assign add_im_s[j] = sext(twd_10_sum_im[j]) + sext(twd_10_sum_im[j+HALF_LANES]);
            assign sub_re_s[j] = sext(twd_10_sum_re[j]) - sext(twd_10_sum_re[j+HALF_LANES]);
            assign sub_im_s[j] = sext(twd_10_sum_im[j]) - sext(twd_10_sum_im[j+HALF_LANES]);

            assign add_re_s[j+HALF_LANES] = sext(twd_10_diff_re[j]) + sext(twd_10_diff_re[j+HALF_LANES]);
            assign add_im_s[j+HALF_LANES] = sext(twd_10_diff_im[j]) + sext(twd_10_diff_im[j+HALF_LANES]);
            assign sub_re_s[j+HALF_LANES] = sext(twd_10_diff_re[j]) - sext(twd_10_diff_re[j+HALF_LANES]);
            assign sub_im_s[j+HALF_LANES] = sext(twd_10_diff_im[j]) - sext(twd_10_diff_im[j+HALF_LANES]);
        end
    endgenerate

    // Counter value is the index of the beat being accepted this cycle.
    counter #(
        .COUNT_MAX_VAL(CLK_CNT),
        .CW           (4)
    ) u_beat_cnt (
        .clk  (clk),
        .rstn (rstn),
        .en   (twd10_valid),
        .count(beat_cnt_s)
    );

    // output registers: load on a valid beat, otherwise hold the last presented beat
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < LANES; i++) begin
                o_11bfly_sum_re[i]  <= {OW{1'b0}};
                o_11bfly_sum_im[i]  <= {OW{1'b0}};
                o_11bfly_diff_re[i] <= {OW{1'b0}};
                o_11bfly_diff_im[i] <= {OW{1'b0}};
            end
            twd11_valid  <= 1'b0;
            o_beat_idx   <= 4'd0;
            o_frame_last <= 1'b0;
        end else begin
            twd11_valid <= twd10_valid;
            if (twd10_valid) begin
                for (int i = 0; i < LANES; i++) begin
                    o_11bfly_sum_re[i]  <= add_re_s[i];
                    o_11bfly_sum_im[i]  <= add_im_s[i];
                    o_11bfly_diff_re[i] <= sub_re_s[i];
                    o_11bfly_diff_im[i] <= sub_im_s[i];
                end
                o_beat_idx   <= beat_cnt_s;
                o_frame_last <= (beat_cnt_s == 4'(CLK_CNT - 1));
            end
        end
    end

endmodule

// File: tb/tb_bfly11_stage.sv
// Directed bench for bfly11_stage: an arithmetic reference model checked every cycle,
// plus hand-computed expectations that pin the model.
module tb_bfly11_stage;

    localparam int W  = 12;
    localparam int CC = 4;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic valid_in = 1'b0;
    logic signed [W-1:0] s_re [0:15];
    logic signed [W-1:0] s_im [0:15];
    logic signed [W-1:0] d_re [0:15];
    logic signed [W-1:0] d_im [0:15];
    logic signed [W:0]   o_s_re [0:15];
    logic signed [W:0]   o_s_im [0:15];
    logic signed [W:0]   o_d_re [0:15];
    logic signed [W:0]   o_d_im [0:15];
    logic       v_out;
    logic [3:0] idx_out;
    logic       last_out;

    int n_cmp  = 0;
    int n_fail = 0;

    bfly11_stage #(.WIDTH(W), .CLK_CNT(CC)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .twd10_valid     (valid_in),
        .twd_10_sum_re   (s_re),
        .twd_10_sum_im   (s_im),
        .twd_10_diff_re  (d_re),
        .twd_10_diff_im  (d_im),
        .o_11bfly_sum_re (o_s_re),
        .o_11bfly_sum_im (o_s_im),
        .o_11bfly_diff_re(o_d_re),
        .o_11bfly_diff_im(o_d_im),
        .twd11_valid     (v_out),
        .o_beat_idx      (idx_out),
        .o_frame_last    (last_out)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer butterfly plus a running count of accepted beats.
    int m_s_re [16];
    int m_s_im [16];
    int m_d_re [16];
    int m_d_im [16];
    int m_valid = 0;
    int m_idx = 0;
    int m_last = 0;
    int m_beats = 0;
    bit model_live = 1'b0;

    always @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < 16; i++) begin
                m_s_re[i] = 0; m_s_im[i] = 0; m_d_re[i] = 0; m_d_im[i] = 0;
            end
            m_valid = 0; m_idx = 0; m_last = 0; m_beats = 0;
            model_live = 1'b1;
        end else begin
            m_valid = valid_in ? 1 : 0;
            if (valid_in) begin
                for (int i = 0; i < 8; i++) begin
                    m_s_re[i]   = int'(s_re[i]) + int'(s_re[i+8]);
                    m_d_re[i]   = int'(s_re[i]) - int'(s_re[i+8]);
                    m_s_im[i]   = int'(s_im[i]) + int'(s_im[i+8]);
                    m_d_im[i]   = int'(s_im[i]) - int'(s_im[i+8]);
                    m_s_re[i+8] = int'(d_re[i]) + int'(d_re[i+8]);
                    m_d_re[i+8] = int'(d_re[i]) - int'(d_re[i+8]);
                    m_s_im[i+8] = int'(d_im[i]) + int'(d_im[i+8]);
                    m_d_im[i+8] = int'(d_im[i]) - int'(d_im[i+8]);
                end
                m_idx  = m_beats % CC;
                m_last = (m_idx == CC - 1) ? 1 : 0;
                m_beats++;
            end
        end
    end

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // Every-cycle comparison against the model, on the falling edge.
    always @(negedge clk) begin
        if (model_live) begin
            for (int i = 0; i < 16; i++) begin
                chk($sformatf("mdl sum_re[%0d]", i),  32'($signed(o_s_re[i])), m_s_re[i]);
                chk($sformatf("mdl sum_im[%0d]", i),  32'($signed(o_s_im[i])), m_s_im[i]);
                chk($sformatf("mdl diff_re[%0d]", i), 32'($signed(o_d_re[i])), m_d_re[i]);
                chk($sformatf("mdl diff_im[%0d]", i), 32'($signed(o_d_im[i])), m_d_im[i]);
            end
            chk("mdl valid", 32'(v_out), m_valid);
            chk("mdl idx",   32'(idx_out), m_idx);
            chk("mdl last",  32'(last_out), m_last);
        end
    end

    task automatic clear_in();
        for (int i = 0; i < 16; i++) begin
            s_re[i] = 12'sd0; s_im[i] = 12'sd0; d_re[i] = 12'sd0; d_im[i] = 12'sd0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_in();
        step();
        step();
        chk("rst valid", 32'(v_out), 0);
        chk("rst idx", 32'(idx_out), 0);
        chk("rst sum_re0", 32'($signed(o_s_re[0])), 0);
        rstn = 1'b1;

        // single lane pair: 1 and 100
        valid_in = 1'b1;
        s_re[1] = 12'sd1; s_re[9] = 12'sd100;
        step();
        chk("t29 sum_re1", 32'($signed(o_s_re[1])), 101);
        chk("t29 diff_re1", 32'($signed(o_d_re[1])), -99);
        chk("t29 valid", 32'(v_out), 1);
        chk("t29 idx", 32'(idx_out), 0);

        // extremes: growth into the guard bit
        clear_in();
        s_re[0] = 12'sd2047; s_re[8] = 12'sd2047;
        step();
        chk("t30 sum_re0 max", 32'($signed(o_s_re[0])), 4094);
        chk("t30 idx", 32'(idx_out), 1);
        s_re[0] = -12'sd2048; s_re[8] = 12'sd2047;
        step();
        chk("t30 diff_re0 min", 32'($signed(o_d_re[0])), -4095);
        chk("t30 sum_re0 mix", 32'($signed(o_s_re[0])), -1);

        // diff-lane group lands in output lanes 8..15
        clear_in();
        d_im[3] = 12'sd5; d_im[11] = 12'sd7;
        step();
        chk("t31 sum_im11", 32'($signed(o_s_im[11])), 12);
        chk("t31 diff_im11", 32'($signed(o_d_im[11])), -2);
        chk("t31 sum_im3", 32'($signed(o_s_im[3])), 0);
        chk("t31 last", 32'(last_out), 1);

        // eight back-to-back beats with a deterministic lane pattern
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < 16; i++) begin
                s_re[i] = 12'((k * 37 + i * 91) % 4096 - 2048);
                s_im[i] = 12'((k * 53 + i * 17 + 1000) % 4096 - 2048);
                d_re[i] = 12'((k * 71 + i * 29 + 300) % 4096 - 2048);
                d_im[i] = 12'((k * 13 + i * 211 + 2000) % 4096 - 2048);
            end
            step();
            chk($sformatf("t32 idx beat%0d", k), 32'(idx_out), k % 4);
            chk($sformatf("t32 last beat%0d", k), 32'(last_out), (k % 4 == 3) ? 1 : 0);
        end

        // valid pattern 1,0,0,1 with changing inputs during the gap
        clear_in();
        s_re[0] = 12'sd10; s_re[8] = 12'sd3;
        step();
        chk("t33 idx first", 32'(idx_out), 0);
        chk("t33 sum_re0", 32'($signed(o_s_re[0])), 13);
        valid_in = 1'b0;
        s_re[0] = 12'sd500; s_re[8] = 12'sd500;
        step();
        chk("t33 gap valid", 32'(v_out), 0);
        step();
        chk("t33 hold sum_re0", 32'($signed(o_s_re[0])), 13);
        chk("t33 hold idx", 32'(idx_out), 0);
        valid_in = 1'b1;
        step();
        chk("t33 idx second", 32'(idx_out), 1);
        chk("t33 sum_re0 new", 32'($signed(o_s_re[0])), 1000);

        // beat 2, then reset mid-frame with a valid beat present
        step();
        chk("t34 idx before rst", 32'(idx_out), 2);
        rstn = 1'b0;
        step();
        chk("t34 rst valid", 32'(v_out), 0);
        chk("t34 rst sum_re0", 32'($signed(o_s_re[0])), 0);
        chk("t34 rst idx", 32'(idx_out), 0);
        rstn = 1'b1;
        step();
        chk("t34 idx after rst", 32'(idx_out), 0);
        chk("t34 valid after rst", 32'(v_out), 1);
        valid_in = 1'b0;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
